// File: rtl/fastpath_pkg.sv
// Shared types and sizing helpers for the fast-path serial sum unit.
// Optional macro FASTPATH_CONST_TIME_EN is consumed by fastpath_serial_acc.
package fastpath_pkg;

    // Control FSM states of the top level.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Smallest index counter width allowed, even for a hypothetical single channel.
    localparam int unsigned MIN_IDX_WIDTH = 1;

    // Result width: wide enough that NCH * (2^W - 1) can never wrap.
    function automatic int unsigned sum_width(input int unsigned nch, input int unsigned w);
        return w + $clog2(nch);
    endfunction

    // Operand index counter width, $clog2(nch) with a floor of one bit.
    function automatic int unsigned idx_width(input int unsigned nch);
        return ($clog2(nch) < MIN_IDX_WIDTH) ? MIN_IDX_WIDTH : $clog2(nch);
    endfunction

endpackage

// File: rtl/fastpath_serial_acc.sv
// Datapath of the fast-path sum unit: captures an operand bundle, walks it one
// operand per step into an accumulator, and flags all-zero bundles.
// When FASTPATH_CONST_TIME_EN is defined the zero detect is removed so no
// data-dependent signal leaves this block towards the control FSM.
module fastpath_serial_acc
    import fastpath_pkg::*;
#(
    parameter int unsigned NCH = 2,
    parameter int unsigned W   = 2,
    localparam int unsigned SW = sum_width(NCH, W),
    localparam int unsigned IW = idx_width(NCH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [NCH*W-1:0] i_data,
    output logic [SW-1:0]    o_sum_next,
    output logic             o_last,
    output logic             o_all_zero
);

    logic [NCH*W-1:0] r_ops;
    logic [IW-1:0]    r_idx;
    logic [SW-1:0]    r_acc;
    logic [W-1:0]     w_op;

    // Operand selected by the running index, zero-extended into the adder.
    always_comb begin
        w_op       = r_ops[int'(r_idx) * int'(W) +: W];
        o_sum_next = r_acc + SW'(w_op);
        o_last     = (r_idx == IW'(NCH - 1));
    end

    // Zero detect looks at the incoming bundle so the branch is taken at the accept edge.
    always_comb begin
`ifdef FASTPATH_CONST_TIME_EN
        o_all_zero = 1'b0;
`else
        o_all_zero = (i_data == '0);
`endif
    end

    // Operand capture on accept; one accumulate step per ACC cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ops <= '0;
            r_idx <= '0;
            r_acc <= '0;
        end else if (i_load) begin
            r_ops <= i_data;
            r_idx <= '0;
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= o_sum_next;
            r_idx <= r_idx + IW'(1);
        end
    end

endmodule

// File: rtl/fastpath_sum_unit.sv
// Serial NCH-operand summer with valid/ready on both sides. An all-zero bundle
// returns 0 after one cycle (out_fast=1); anything else takes NCH+1 cycles.
// Define FASTPATH_CONST_TIME_EN to force every bundle down the slow path so
// latency no longer depends on in_data.
module fastpath_sum_unit
    import fastpath_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned W       = 2,
    parameter int unsigned RST_VAL = 0,
    localparam int unsigned SW     = sum_width(NCH, W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NCH*W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out_data,
    output logic             out_fast
);

    state_e        r_state;
    logic          r_out_valid;
    logic          r_out_fast;
    logic [SW-1:0] r_out_data;

    logic          w_accept;
    logic          w_step;
    logic          w_last;
    logic          w_all_zero;
    logic [SW-1:0] w_sum_next;

    // Ready depends only on state and out_ready, never on in_valid.
    always_comb begin
        in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
        w_accept = in_valid & in_ready;
        w_step   = (r_state == ACC);
    end

    fastpath_serial_acc #(
        .NCH (NCH),
        .W   (W)
    ) u_acc (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_data     (in_data),
        .o_sum_next (w_sum_next),
        .o_last     (w_last),
        .o_all_zero (w_all_zero)
    );

    // Control FSM; outputs change only on entry to DONE or on leaving it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_fast  <= 1'b0;
            r_out_data  <= SW'(RST_VAL);
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        // Covers back-to-back accept in DONE during the output handshake.
                        if (w_all_zero) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_out_fast  <= 1'b1;
                            r_out_data  <= '0;
                        end else begin
                            r_state     <= ACC;
                            r_out_valid <= 1'b0;
                            r_out_fast  <= 1'b0;
                        end
                    end else if ((r_state == DONE) && out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                ACC: begin
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_out_fast  <= 1'b0;
                        r_out_data  <= w_sum_next;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_fast  = r_out_fast;

endmodule

// File: tb/tb_fastpath_sum_unit.sv
// Bench for fastpath_sum_unit: instance A (NCH=2, W=2, RST_VAL=5) is checked
// every cycle against a transaction-timeline model; instance B (NCH=4, W=2)
// gets directed bundles with hand-computed results.
module tb_fastpath_sum_unit;

    localparam int unsigned A_NCH = 2;
    localparam int unsigned A_W   = 2;
    localparam int unsigned A_SW  = 3;
    localparam int unsigned A_RST = 5;
    localparam int unsigned B_NCH = 4;
    localparam int unsigned B_W   = 2;
    localparam int unsigned B_SW  = 4;

`ifdef FASTPATH_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [A_NCH*A_W-1:0]   in_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [A_SW-1:0]        out_data;
    logic                   out_fast;

    logic                   b_in_valid = 1'b0;
    logic                   b_in_ready;
    logic [B_NCH*B_W-1:0]   b_in_data = '0;
    logic                   b_out_valid;
    logic                   b_out_ready = 1'b1;
    logic [B_SW-1:0]        b_out_data;
    logic                   b_out_fast;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fastpath_sum_unit #(
        .NCH     (A_NCH),
        .W       (A_W),
        .RST_VAL (A_RST)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_fast  (out_fast)
    );

    fastpath_sum_unit #(
        .NCH (B_NCH),
        .W   (B_W)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_fast  (b_out_fast)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int sum_a(input logic [A_NCH*A_W-1:0] d);
        int s = 0;
        for (int i = 0; i < int'(A_NCH); i++) s += int'(d[i*A_W +: A_W]);
        return s;
    endfunction

    function automatic int sum_b(input logic [B_NCH*B_W-1:0] d);
        int s = 0;
        for (int i = 0; i < int'(B_NCH); i++) s += int'(d[i*B_W +: B_W]);
        return s;
    endfunction

    // Transaction-timeline model of instance A: which bundle is outstanding,
    // the cycle its result becomes visible, and the value shown on out_data.
    int  cyc = 0;
    bit  m_init = 1'b0;
    bit  m_pend = 1'b0;
    bit  m_val  = 1'b0;
    bit  m_fast = 1'b0;
    int  m_data = 0;
    int  m_due  = 0;
    int  p_sum  = 0;
    bit  p_fast = 1'b0;
    bit  m_rdy;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_pend = 1'b0;
            m_val  = 1'b0;
            m_fast = 1'b0;
            m_data = A_RST;
        end else begin
            m_rdy = !m_pend || (m_val && out_ready);
            if (m_val && out_ready) begin
                m_val  = 1'b0;
                m_pend = 1'b0;
            end
            if (in_valid && m_rdy) begin
                p_sum  = sum_a(in_data);
                p_fast = !CONST_TIME && (in_data == '0);
                m_due  = cyc + (p_fast ? 0 : int'(A_NCH));
                m_pend = 1'b1;
            end
            if (m_pend && !m_val && cyc == m_due) begin
                m_val  = 1'b1;
                m_data = p_sum;
                m_fast = p_fast;
            end
        end
        m_init = 1'b1;
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            check("a_in_ready", int'(in_ready), int'(!m_pend || (m_val && out_ready)));
            check("a_out_valid", int'(out_valid), int'(m_val));
            check("a_out_data", int'(out_data), m_data);
            if (m_val) check("a_out_fast", int'(out_fast), int'(m_fast));
        end
    end

    task automatic wait_a_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("a_ready_timeout", 0, 1);
    endtask

    // Single bundle on A from idle; latency counted from the accept edge.
    task automatic a_directed(input string name, input logic [A_NCH*A_W-1:0] d,
                              input int exp_sum, input int exp_lat, input bit exp_fast);
        int lat;
        wait_a_ready();
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_data"}, int'(out_data), exp_sum);
        check({name, "_fast"}, int'(out_fast), int'(exp_fast));
    endtask

    task automatic b_directed(input string name, input logic [B_NCH*B_W-1:0] d,
                              input int exp_sum, input int exp_lat, input bit exp_fast);
        int lat;
        int n = 0;
        while (!b_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_ready"}, int'(b_in_ready), 1);
        b_in_data  = d;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_data"}, int'(b_out_data), exp_sum);
        check({name, "_fast"}, int'(b_out_fast), int'(exp_fast));
    endtask

    initial begin
        logic [B_NCH*B_W-1:0] bd;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_valid", int'(out_valid), 0);
        check("rst_a_data", int'(out_data), 5);
        check("rst_a_ready", int'(in_ready), 1);
        check("rst_b_valid", int'(b_out_valid), 0);
        check("rst_b_data", int'(b_out_data), 0);
        check("rst_b_fast", int'(b_out_fast), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Literal pins: {2,1} -> 3 slow; zero bundle -> fast 0.
        a_directed("a_2_1", 4'b10_01, 3, 3, 1'b0);
        a_directed("a_zero", 4'b00_00, 0, CONST_TIME ? 3 : 1, !CONST_TIME);
        a_directed("a_3_3", 4'b11_11, 6, 3, 1'b0);

        // B: all operands 3 -> 12 in SW=4 bits, no wrap.
        b_directed("b_all3", 8'hFF, 12, 5, 1'b0);
        b_directed("b_zero", 8'h00, 0, CONST_TIME ? 5 : 1, !CONST_TIME);
        b_directed("b_one", 8'b01_00_00_00, 1, 5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            bd = 8'($urandom);
            b_directed("b_rand", bd, sum_b(bd), (!CONST_TIME && bd == '0) ? 1 : 5,
                       !CONST_TIME && bd == '0);
        end

        // Backpressure: result must hold for 4 cycles while other data is offered.
        wait_a_ready();
        out_ready = 1'b0;
        in_data   = 4'b01_10;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_data = 4'b11_11;
        for (int k = 0; k < 8 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_data", int'(out_data), 3);
            check("bp_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_ready", int'(in_ready), 1);

        // Back-to-back: {1,1} then {0,0} with in_valid held high.
        in_data  = 4'b01_01;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 4'b00_00;
        for (int k = 0; k < 8 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("b2b_first", int'(out_data), 2);
        check("b2b_ready_in_done", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (CONST_TIME) begin
            check("b2b_second_pending", int'(out_valid), 0);
            for (int k = 0; k < 8 && !out_valid; k++) begin
                @(posedge clk); #1;
            end
        end
        check("b2b_second_valid", int'(out_valid), 1);
        check("b2b_second_data", int'(out_data), 0);
        check("b2b_second_fast", int'(out_fast), int'(!CONST_TIME));
        @(posedge clk); #1;

        // Reset during ACC cycle 1 discards the bundle.
        wait_a_ready();
        in_data  = 4'b11_11;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_acc_valid", int'(out_valid), 0);
        check("rst_acc_data", int'(out_data), 5);
        check("rst_acc_ready", int'(in_ready), 1);
        a_directed("a_after_rst", 4'b01_10, 3, 3, 1'b0);

        // Random traffic on A, checked each cycle by the model.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fastpath_sum_unit.md
Name: fastpath_sum_unit

Overview:
- Parametrised successor to the two-input fast-path adder test block.
- Accepts NCH unsigned operands of W bits each through a valid/ready handshake and sums them serially, one operand per cycle.
- Returns the result through a valid/ready handshake.
- When every operand is zero, a fast path returns 0 early; this gives an intentional, data-dependent latency for the constant-time checker benches.

Parameters:
- NCH, 2: number of operand channels, ≥2.
- W, 2: operand width in bits.
- RST_VAL, 0: reset value of out_data.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept a bundle.
- in_data  input  NCH*W  operands; channel i at bits [i*W +: W].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  SW  sum, where SW = W + $clog2(NCH).
- out_fast  output  1  result was produced by the fast path; qualified by out_valid.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- All state updates on posedge clk.
- Reset values: state=IDLE, out_valid=0, out_fast=0, out_data=RST_VAL, internal accumulator and index=0.
- FSM states are IDLE, ACC and DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational, and has no in_valid→in_ready path.
- Accept event: in_valid & in_ready.
  - Captures in_data into the operand register.
  - Clears the accumulator to 0 and sets index to 0.
- Branch on accept:
  - All NCH operands zero (fast path enabled) → DONE next cycle; out_data=0, out_fast=1.
  - Otherwise → ACC.
- ACC:
  - Each cycle, acc <= acc + op[index] (zero-extended to SW) and index++.
  - After the cycle that adds op[NCH-1] → DONE; out_data=final acc, out_fast=0.
  - Exactly NCH cycles in ACC.
- DONE:
  - out_valid=1; out_data and out_fast are held stable until the handshake.
  - On out_ready with no in_valid → IDLE.
  - On out_ready with in_valid → accept the new bundle in the same cycle (back-to-back; no IDLE bubble) and branch as above.
- Latency from the accept edge to out_valid high:
  - Fast path: 1 cycle.
  - Slow path: NCH+1 cycles.
- Throughput: one bundle per (latency) cycles.
- Width: SW bits never overflow; maximum sum NCH*(2^W-1) fits. No wrap and no saturation logic needed.
- out_data updates only on entry to DONE; it holds its value in IDLE and ACC. It is not cleared after a handshake.
- in_data is ignored while in_ready=0; changes on in_data during ACC have no effect.
- Reset mid-operation (ACC or DONE): transaction is discarded with no output, and all reset values apply the following cycle.
- out_ready asserted while out_valid=0: ignored.

Optional Feature:
- Macro: FASTPATH_CONST_TIME_EN.
- Defined:
  - Zero detect is disabled; every bundle takes the ACC path.
  - Latency is always NCH+1 regardless of data.
  - out_fast is tied to 0.
  - The block must pass the taint/constant-time check with in_data as source and out_valid as sink.
- Undefined: fast path as described above. This is the negative-test configuration.

Decomposition:
- Package fastpath_pkg:
  - State enum {IDLE, ACC, DONE}.
  - Function sum_width(nch, w) returning w + $clog2(nch).
  - Localparam for index width, $clog2(NCH) with a minimum of 1.
- Sub-module fastpath_serial_acc contains:
  - Operand register.
  - Index counter.
  - Accumulator.
  - all_zero detect.
- The top holds the FSM and handshakes.

Test Plan:
- NCH=2, W=2, in_data={2'd2,2'd1}, out_ready=1 → out_valid 3 cycles after accept, out_data=3, out_fast=0.
- NCH=2, W=2, in_data=0 → out_valid 1 cycle after accept, out_data=0, out_fast=1. With FASTPATH_CONST_TIME_EN: 3 cycles, out_fast=0.
- NCH=4, W=2, all operands 3 → out_data=12 (SW=4) after 5 cycles; no overflow.
- Backpressure: hold out_ready=0 for 4 cycles in DONE → out_valid, out_data and out_fast stable, in_ready=0; release → IDLE.
- Back-to-back: in_valid held high with bundles {1,1} then {0,0}, out_ready=1 → results 2 then 0; second accept in the same cycle as the first output handshake.
- Assert rst during ACC cycle 1 → next cycle out_valid=0, out_data=RST_VAL, in_ready=1; the next bundle is processed normally.
